note_sequencer: RTL and testbench

// - Song-step fetch and channel gating stage. Sits directly downstream of the top-level state machine.
// - Uses the 2-bit state code (00=RESET, 01=LOAD, 10=START, 11=PLAY) to read one song step per

---
 rtl/note_sequencer.sv | 135 +++++++++++++
 tb/tb_note_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Song-step fetch and channel gating: reads one ROM step per LOAD/START pair,
// latches note codes, pulses triggers and times each channel's gate.
module note_sequencer #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 8,
  parameter int NOTE_W    = 7,
  parameter int LEN_W     = 6,
  parameter int TICK_LOG2 = 14
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [1:0]                       state,
  output logic                             rom_en,
  output logic [ADDR_W-1:0]                rom_addr,
  input  logic [NUM_CH*(NOTE_W+LEN_W)-1:0] rom_data,
  output logic [NUM_CH*NOTE_W-1:0]         note,
  output logic [NUM_CH-1:0]                trigger,
  output logic [NUM_CH-1:0]                gate,
  output logic                             song_done
);

  localparam int FW = NOTE_W + LEN_W;
  localparam int CW = LEN_W + TICK_LOG2;

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_LOAD  = 2'b01,
    ST_START = 2'b10,
    ST_PLAY  = 2'b11
  } state_e;

  state_e                    state_s;
  logic [NOTE_W-1:0]         fld_note_s [NUM_CH];
  logic [LEN_W-1:0]          fld_len_s  [NUM_CH];
  logic                      end_mark_s;

  logic [ADDR_W-1:0]         ptr_q, ptr_d;
  logic [NUM_CH*NOTE_W-1:0]  note_q, note_d;
  logic [NUM_CH-1:0]         trigger_q, trigger_d;
  logic [NUM_CH-1:0]         gate_q, gate_d;
  logic                      song_done_q, song_done_d;
  logic [CW-1:0]             cnt_q [NUM_CH];
  logic [CW-1:0]             cnt_d [NUM_CH];

  assign state_s = state_e'(state);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fields
    assign fld_len_s[g]  = rom_data[g*FW +: LEN_W];
    assign fld_note_s[g] = rom_data[g*FW + LEN_W +: NOTE_W];
  end

  assign end_mark_s = (fld_note_s[0] == {NOTE_W{1'b1}});
  assign rom_en     = reset_n & (state_s == ST_LOAD);
  assign rom_addr   = ptr_q;
  assign note       = note_q;
  assign trigger    = trigger_q;
  assign gate       = gate_q;
  assign song_done  = song_done_q;

  // Next-state: counters free-run down, START reloads them, RESET clears.
  always_comb begin
    ptr_d       = ptr_q;
    note_d      = note_q;
    trigger_d   = {NUM_CH{1'b0}};
    song_done_d = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (cnt_q[ch] != {CW{1'b0}}) begin
        cnt_d[ch] = cnt_q[ch] - CW'(1);
      end else begin
        cnt_d[ch] = {CW{1'b0}};
      end
    end

    case (state_s)
      ST_RESET: begin
        ptr_d  = {ADDR_W{1'b0}};
        note_d = {(NUM_CH*NOTE_W){1'b0}};
        for (int ch = 0; ch < NUM_CH; ch++) begin
          cnt_d[ch] = {CW{1'b0}};
        end
      end
      ST_START: begin
        if (end_mark_s) begin
          song_done_d = 1'b1;
          ptr_d       = {ADDR_W{1'b0}};
          for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt_d[ch] = {CW{1'b0}};
          end
        end else begin
          // Pointer wraps silently at the top of the ROM.
          ptr_d = ptr_q + ADDR_W'(1);
          for (int ch = 0; ch < NUM_CH; ch++) begin
            note_d[ch*NOTE_W +: NOTE_W] = fld_note_s[ch];
            if ((fld_note_s[ch] != {NOTE_W{1'b0}}) && (fld_len_s[ch] != {LEN_W{1'b0}})) begin
              cnt_d[ch]     = CW'(fld_len_s[ch]) << TICK_LOG2;
              trigger_d[ch] = 1'b1;
            end else begin
              cnt_d[ch] = {CW{1'b0}};
            end
          end
        end
      end
      default: begin
      end
    endcase

    for (int ch = 0; ch < NUM_CH; ch++) begin
      gate_d[ch] = (cnt_d[ch] != {CW{1'b0}});
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= {ADDR_W{1'b0}};
      note_q      <= {(NUM_CH*NOTE_W){1'b0}};
      trigger_q   <= {NUM_CH{1'b0}};
      gate_q      <= {NUM_CH{1'b0}};
      song_done_q <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= {CW{1'b0}};
      end
    end else begin
      ptr_q       <= ptr_d;
      note_q      <= note_d;
      trigger_q   <= trigger_d;
      gate_q      <= gate_d;
      song_done_q <= song_done_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: table-driven song steps, hand-written corner sequences and a
// random phase, all checked against an end-time based reference model of each channel.
module tb_note_sequencer;
  localparam int TICK = 4;  // shortened length unit keeps max-length notes within budget
  localparam int UNIT = 1 << TICK;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  state;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [51:0] rom_data = '0;
  logic [27:0] note;
  logic [3:0]  trigger;
  logic [3:0]  gate;
  logic        song_done;

  logic [51:0] rom [256];

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;

  int          m_ptr;
  logic [6:0]  m_note [4];
  logic [3:0]  m_trig;
  logic        m_done;
  longint      m_end [4];
  logic [51:0] m_rd;

  typedef struct {
    logic [51:0] word;
    int          play_n;
    logic [3:0]  exp_trig;
    logic        exp_done;
    int          exp_addr;
    logic [27:0] exp_note;
  } vec_t;
  vec_t vecs [6];

  note_sequencer #(.NUM_CH(4), .ADDR_W(8), .NOTE_W(7), .LEN_W(6), .TICK_LOG2(TICK)) dut (
    .clk(clk), .reset_n(reset_n), .state(state), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .note(note), .trigger(trigger), .gate(gate), .song_done(song_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) rom_data <= rom[rom_addr];
  end

  function automatic logic [51:0] mk(input int n0, l0, n1, l1, n2, l2, n3, l3);
    return {7'(n3), 6'(l3), 7'(n2), 6'(l2), 7'(n1), 6'(l1), 7'(n0), 6'(l0)};
  endfunction

  function automatic logic [51:0] rnd_word(input bit allow_end);
    int n0;
    n0 = (allow_end && $urandom_range(0, 7) == 0) ? 127 : $urandom_range(0, 126);
    return mk(n0, $urandom_range(0, 63), $urandom_range(0, 127), $urandom_range(0, 63),
              $urandom_range(0, 127), $urandom_range(0, 63), $urandom_range(0, 127),
              $urandom_range(0, 63));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all();
    logic [3:0] eg;
    for (int k = 0; k < 4; k++) eg[k] = (cyc < m_end[k]);
    chk("gate", 64'(gate), 64'(eg));
    chk("trigger", 64'(trigger), 64'(m_trig));
    chk("song_done", 64'(song_done), 64'(m_done));
    chk("note", 64'(note), 64'({m_note[3], m_note[2], m_note[1], m_note[0]}));
    chk("rom_en", 64'(rom_en), 64'(reset_n && state == 2'b01));
    chk("rom_addr", 64'(rom_addr), 64'(m_ptr));
  endtask

  task automatic model_reset();
    m_ptr = 0; m_trig = '0; m_done = 1'b0;
    for (int k = 0; k < 4; k++) begin m_note[k] = '0; m_end[k] = 0; end
  endtask

  task automatic model_edge(input logic [1:0] st);
    longint c;
    int n, l;
    c = cyc + 1;
    m_trig = '0;
    m_done = 1'b0;
    case (st)
      2'b00: begin
        m_ptr = 0;
        for (int k = 0; k < 4; k++) begin m_note[k] = '0; m_end[k] = c; end
      end
      2'b01: m_rd = rom[m_ptr];
      2'b10: begin
        if (m_rd[12:6] == 7'h7F) begin
          m_done = 1'b1;
          m_ptr = 0;
          for (int k = 0; k < 4; k++) m_end[k] = c;
        end else begin
          for (int k = 0; k < 4; k++) begin
            n = int'(m_rd[k*13+6 +: 7]);
            l = int'(m_rd[k*13 +: 6]);
            m_note[k] = 7'(n);
            if (n != 0 && l != 0) begin
              m_end[k] = c + longint'(l * UNIT);
              m_trig[k] = 1'b1;
            end else begin
              m_end[k] = c;
            end
          end
          m_ptr = (m_ptr + 1) % 256;
        end
      end
      default: ;
    endcase
  endtask

  task automatic cycle(input logic [1:0] st);
    state = st;
    model_edge(st);
    @(posedge clk);
    cyc++;
    #1;
    check_all();
  endtask

  initial begin
    reset_n = 1'b0;
    state = 2'b00;
    m_rd = '0;
    model_reset();
    for (int i = 0; i < 256; i++) rom[i] = '0;

    repeat (2) begin @(posedge clk); cyc++; end
    #1;
    check_all();
    reset_n = 1'b1;

    vecs[0] = '{mk(40, 1, 0, 0, 0, 0, 0, 0), 20, 4'b0001, 1'b0, 1, {7'd0, 7'd0, 7'd0, 7'd40}};
    vecs[1] = '{mk(0, 0, 50, 63, 0, 0, 0, 0), 1010, 4'b0010, 1'b0, 2, {7'd0, 7'd0, 7'd50, 7'd0}};
    vecs[2] = '{mk(0, 0, 0, 0, 60, 63, 0, 0), 30, 4'b0100, 1'b0, 3, {7'd0, 7'd60, 7'd0, 7'd0}};
    vecs[3] = '{mk(0, 0, 0, 0, 61, 2, 70, 0), 40, 4'b0100, 1'b0, 4, {7'd70, 7'd61, 7'd0, 7'd0}};
    vecs[4] = '{mk(10, 3, 0, 5, 20, 1, 30, 2), 10, 4'b1101, 1'b0, 5, {7'd30, 7'd20, 7'd0, 7'd10}};
    vecs[5] = '{mk(127, 5, 1, 1, 2, 2, 3, 3), 5, 4'b0000, 1'b1, 0, {7'd30, 7'd20, 7'd0, 7'd10}};
    for (int i = 0; i < 6; i++) rom[i] = vecs[i].word;

    for (int i = 0; i < 6; i++) begin
      cycle(2'b01);
      cycle(2'b10);
      chk("vec_trigger", 64'(trigger), 64'(vecs[i].exp_trig));
      chk("vec_song_done", 64'(song_done), 64'(vecs[i].exp_done));
      chk("vec_ptr", 64'(rom_addr), 64'(vecs[i].exp_addr));
      chk("vec_note", 64'(note), 64'(vecs[i].exp_note));
      repeat (vecs[i].play_n) cycle(2'b11);
    end
    cycle(2'b01);
    chk("after_end_addr", 64'(rom_addr), 64'd0);
    cycle(2'b10);
    cycle(2'b11);

    // async reset mid-PLAY with every gate running
    rom[1] = mk(1, 4, 2, 4, 3, 4, 4, 4);
    cycle(2'b01);
    cycle(2'b10);
    repeat (5) cycle(2'b11);
    chk("all_gates_on", 64'(gate), 64'hF);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_gate", 64'(gate), 64'd0);
    chk("async_note", 64'(note), 64'd0);
    chk("async_ptr", 64'(rom_addr), 64'd0);
    check_all();
    @(posedge clk);
    cyc++;
    #1;
    reset_n = 1'b1;
    check_all();
    state = 2'b01;
    #1;
    chk("first_load_en", 64'(rom_en), 64'd1);
    chk("first_load_addr", 64'(rom_addr), 64'd0);
    cycle(2'b01);
    cycle(2'b10);
    cycle(2'b11);

    // full pass through the ROM: pointer wraps without song_done
    for (int i = 0; i < 256; i++) rom[i] = rnd_word(1'b0);
    cycle(2'b00);
    for (int i = 0; i < 257; i++) begin
      cycle(2'b01);
      cycle(2'b10);
      if (i == 255) begin
        chk("wrap_ptr", 64'(rom_addr), 64'd0);
        chk("wrap_no_done", 64'(song_done), 64'd0);
      end
      cycle(2'b11);
    end

    // one RESET state cycle mid-PLAY
    rom[m_ptr] = mk(5, 10, 6, 10, 7, 10, 8, 10);
    cycle(2'b01);
    cycle(2'b10);
    repeat (3) cycle(2'b11);
    cycle(2'b00);
    chk("sreset_gate", 64'(gate), 64'd0);
    chk("sreset_note", 64'(note), 64'd0);
    chk("sreset_ptr", 64'(rom_addr), 64'd0);
    cycle(2'b11);

    // random states, including out-of-order LOAD/START and end markers
    for (int i = 0; i < 256; i++) rom[i] = rnd_word(1'b1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) cycle(2'b00);
      else cycle(2'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
